// File: rtl/backtrack_unwinder_pkg.sv
// backtrack_unwinder_pkg: shared types and sizes for the backtrack unwinder.
package backtrack_unwinder_pkg;
  localparam int MAX_VARS = 64;
  localparam int MAX_VARS_BITS = $clog2(MAX_VARS);
  typedef enum logic [1:0] {
    VAL_UNASSIGNED = 2'b00,
    VAL_FALSE      = 2'b01,
    VAL_TRUE       = 2'b10
  } var_val_t;
  typedef struct packed {
    logic [MAX_VARS_BITS-1:0] var_idx;
    var_val_t                 val;
    logic                     is_dec;
    logic                     flipped;
  } trail_entry_t;
  typedef enum logic [1:0] {BT_IDLE, BT_UNWIND, BT_DONE, BT_UNSAT} bt_state_t;
  function automatic var_val_t invert_val(input var_val_t v);
    return v == VAL_TRUE ? VAL_FALSE : v == VAL_FALSE ? VAL_TRUE : VAL_UNASSIGNED;
  endfunction
endpackage

// File: rtl/backtrack_unwinder.sv
// backtrack_unwinder: pops trail and decision stack in lockstep back to the newest unflipped decision.
// Optional BT_CHECK_EN: cross-checks dec_idx against the trail variable on every decision pop.
module backtrack_unwinder
  import backtrack_unwinder_pkg::*;
#(
  parameter int CNT_BITS = 8
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_conflict,
  output logic                     o_dec_pop,
  input  logic [MAX_VARS_BITS-1:0] i_dec_idx,
  input  logic                     i_dec_empty,
  output logic                     o_trail_pop,
  input  trail_entry_t             i_trail_entry,
  input  logic                     i_trail_empty,
  output logic                     o_var_wr_en,
  output logic [MAX_VARS_BITS-1:0] o_var_wr_idx,
  output var_val_t                 o_var_wr_val,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [MAX_VARS_BITS-1:0] o_resume_idx,
  output var_val_t                 o_resume_val,
  output logic                     o_unsat,
  output logic [CNT_BITS-1:0]      o_unwound_cnt,
  output logic                     o_mismatch
);
  bt_state_t                r_state, w_next;
  logic [CNT_BITS-1:0]      r_cnt;
  logic                     r_mismatch;
  logic [MAX_VARS_BITS-1:0] r_resume_idx;
  var_val_t                 r_resume_val;
  logic                     w_tpop, w_is_dec, w_dpop, w_bad, w_mis_set, w_resume;
  // strobes are gated by reset so the reset cycle never pops
  assign w_tpop   = r_state == BT_UNWIND && !i_reset && !i_trail_empty;
  assign w_is_dec = w_tpop && i_trail_entry.is_dec;
  assign w_dpop   = w_is_dec && !i_dec_empty;
`ifdef BT_CHECK_EN
  assign w_bad     = w_dpop && i_dec_idx != i_trail_entry.var_idx;
  assign w_mis_set = w_bad || (w_is_dec && i_dec_empty);
`else
  logic w_unused;
  assign w_unused  = ^i_dec_idx;
  assign w_bad     = 1'b0;
  assign w_mis_set = 1'b0;
`endif
  assign w_resume = w_is_dec && !i_trail_entry.flipped && !w_bad;
  always_comb begin
    w_next = r_state;
    w_next = r_state == BT_IDLE   ? (i_conflict ? BT_UNWIND : BT_IDLE) :
             r_state == BT_UNWIND ? ((i_trail_empty || w_bad) ? BT_UNSAT :
                                     w_resume ? BT_DONE : BT_UNWIND) :
             r_state == BT_DONE   ? BT_IDLE : BT_UNSAT;
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= BT_IDLE;
      r_cnt        <= '0;
      r_mismatch   <= 1'b0;
      r_resume_idx <= '0;
      r_resume_val <= VAL_UNASSIGNED;
    end else begin
      r_state <= w_next;
      if (r_state == BT_IDLE && i_conflict) r_cnt <= '0;
      else if (w_tpop && r_cnt != '1) r_cnt <= r_cnt + CNT_BITS'(1);
      if (w_mis_set) r_mismatch <= 1'b1;
      if (w_resume) begin
        r_resume_idx <= i_trail_entry.var_idx;
        r_resume_val <= invert_val(i_trail_entry.val);
      end
    end
  end
  assign o_trail_pop   = w_tpop;
  assign o_dec_pop     = w_dpop;
  assign o_var_wr_en   = w_tpop;
  assign o_var_wr_idx  = i_trail_entry.var_idx;
  assign o_var_wr_val  = VAL_UNASSIGNED;
  assign o_busy        = r_state == BT_UNWIND;
  assign o_done        = r_state == BT_DONE;
  assign o_unsat       = r_state == BT_UNSAT;
  assign o_resume_idx  = r_resume_idx;
  assign o_resume_val  = r_resume_val;
  assign o_unwound_cnt = r_cnt;
  assign o_mismatch    = r_mismatch;
endmodule

// File: doc/backtrack_unwinder.md
Name: backtrack_unwinder

Overview:
- Consumer end of the decision stack.
- On a conflict, it pops the assignment trail and the decision stack in lockstep and writes UNASSIGNED to the variable-state table for every undone variable.
- It stops at the most recent decision whose flipped bit is clear, then hands the decider that variable and its opposite polarity, or reports UNSAT.
- Sits between the conflict detector, the decider stack, the trail stack, and the decider control.

Parameters:
- MAX_VARS, 64, maximum variable count (from sysdefs package).
- MAX_VARS_BITS, 6, index width, $clog2(MAX_VARS).
- CNT_BITS, 8, width of the unwound-entry counter (saturating).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- conflict  in  1  start strobe from conflict detector
- dec_pop  out  1  pop strobe to decider stack
- dec_idx  in  MAX_VARS_BITS  top-of-stack index, valid in the same cycle as dec_pop
- dec_empty  in  1  decider stack empty
- trail_pop  out  1  pop strobe to trail stack
- trail_entry  in  trail_entry_t  top trail entry {var, val, is_dec, flipped}, valid in the same cycle as trail_pop
- trail_empty  in  1  trail empty
- var_wr_en  out  1  variable-state write enable
- var_wr_idx  out  MAX_VARS_BITS  variable to write
- var_wr_val  out  var_val_t  value written (always VAL_UNASSIGNED)
- busy  out  1  unwinding in progress
- done  out  1  one-cycle pulse: resume outputs valid
- resume_idx  out  MAX_VARS_BITS  decision variable to re-assign
- resume_val  out  var_val_t  opposite of that decision's original value
- unsat  out  1  sticky: no unflipped decision remains
- unwound_cnt  out  CNT_BITS  entries popped in last backtrack, saturating
- mismatch  out  1  sticky consistency error (see Optional Feature)

Behaviour:
- Reset values: all outputs 0, resume_val=VAL_UNASSIGNED, state IDLE. No pops are issued in the reset cycle.
- States: IDLE, UNWIND, DONE, UNSAT.
- IDLE:
  - conflict=1 and unsat=0 → UNWIND next cycle; clear unwound_cnt; busy=1 from that cycle.
  - conflict while unsat=1 is ignored.
- UNWIND, one trail entry per cycle:
  - trail_empty=1: no pops; go to UNSAT.
  - Otherwise: trail_pop=1; var_wr_en=1, var_wr_idx=trail_entry.var, var_wr_val=VAL_UNASSIGNED; unwound_cnt+1, saturating at all-ones.
  - If trail_entry.is_dec=1: dec_pop=1 in the same cycle. If dec_empty=1, do not pop and set mismatch.
  - If is_dec=1 and flipped=0: register resume_idx=trail_entry.var and resume_val = VAL_TRUE↔VAL_FALSE swap; go to DONE.
  - If is_dec=1 and flipped=1: the decision is exhausted; continue UNWIND.
  - Implied entries (is_dec=0): continue UNWIND.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. resume_* hold until the next conflict.
- UNSAT: unsat=1 and held until reset; busy=0; no strobes.
- conflict asserted during UNWIND or DONE is ignored (not queued).
- dec_pop and trail_pop are never asserted when the matching empty flag is high.
- Latency: N trail entries popped → done asserts N+1 cycles after the conflict cycle.
- Reset mid-UNWIND: next cycle is IDLE with no pops; trail and stack contents are the owner's responsibility.

Optional Feature:
- Macro: BT_CHECK_EN.
- Defined: on every dec_pop cycle, compare dec_idx with trail_entry.var. On inequality, set mismatch (sticky until reset) and go to UNSAT.
- Undefined: no compare, mismatch tied to 0. The dec_empty-on-decision case still only suppresses the pop.

Decomposition:
- sysdefs package: MAX_VARS, MAX_VARS_BITS, var_val_t enum {VAL_UNASSIGNED=2'b00, VAL_FALSE=2'b01, VAL_TRUE=2'b10}, trail_entry_t packed struct, bt_state_t enum.
- No sub-module: a single FSM plus registers; a polarity-invert function in the package.

Test Plan:
- Trail [v3 dec T unflipped, v5 imp F, v7 imp T], stack [3], conflict → writes UNASSIGNED to v7, v5, v3 over 3 cycles; dec_pop only in the v3 cycle; done at cycle 4; resume_idx=3, resume_val=FALSE; unwound_cnt=3.
- Trail [v1 dec F unflipped, v2 dec T flipped, v4 imp F], stack [1,2] → v4, v2, v1 undone; 2 dec pops; resume_idx=1, resume_val=TRUE.
- Trail [v2 dec T flipped], stack [2] → v2 undone, trail empty → unsat=1 and sticky; a later conflict yields no pops.
- Reset asserted in the second UNWIND cycle → next cycle all strobes 0, busy=0, state IDLE.
- BT_CHECK_EN defined, trail decision v6 with dec_idx=4 → mismatch=1, unsat=1. Without the macro → mismatch=0, resume_idx=6.
- 300 implied entries above one decision → unwound_cnt saturates at 255; done still asserts after 302 cycles.
